// File: rtl/instruction_fetch_queue_if.sv
// Fetch-queue bus: memory-controller instruction port, decoder-side queue head,
// and the flush/enable controls shared by both.
interface instruction_fetch_queue_if;
  logic        rdy;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] mc_inst_data;
  logic [31:0] mc_inst_addr;
  logic [1:0]  mc_inst_ready;
  logic        need_instruction;
  logic [31:0] instruction_addr;
  logic        iq_valid;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic [31:0] iq_pred_pc;
  logic        iq_pop;

  // Environment side: controller, decoder and pipeline control.
  modport master (
    output rdy, flush, redirect_pc, mc_inst_data, mc_inst_addr, mc_inst_ready, iq_pop,
    input  need_instruction, instruction_addr, iq_valid, iq_inst, iq_pc, iq_pred_pc
  );

  // Fetch queue side.
  modport slave (
    input  rdy, flush, redirect_pc, mc_inst_data, mc_inst_addr, mc_inst_ready, iq_pop,
    output need_instruction, instruction_addr, iq_valid, iq_inst, iq_pc, iq_pred_pc
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues one word request at a time,
// statically predicts JAL targets and buffers {inst, pc, pred} for the decoder.
module instruction_fetch_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                      clk,
  input logic                      rst,
  instruction_fetch_queue_if.slave fq_io
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] Full = (PtrW + 1)'(DEPTH);

  localparam logic StIdle = 1'b0;
  localparam logic StWait = 1'b1;

  logic            state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PtrW:0]   count_q, count_d;
  logic [31:0]     inst_q [DEPTH];
  logic [31:0]     inst_d [DEPTH];
  logic [31:0]     pc_q   [DEPTH];
  logic [31:0]     pc_d   [DEPTH];
  logic [31:0]     pred_q [DEPTH];
  logic [31:0]     pred_d [DEPTH];
  logic            need_q, need_d;
  logic [31:0]     addr_q, addr_d;
  logic            iq_valid_q, iq_valid_d;
  logic [31:0]     iq_inst_q, iq_inst_d;
  logic [31:0]     iq_pc_q, iq_pc_d;
  logic [31:0]     iq_pred_q, iq_pred_d;

  logic        push, pop;
  logic [31:0] jal_imm, pred;

  // Controller idle flag is informational only; one request is ever outstanding.
  logic unused_mc_idle;
  assign unused_mc_idle = fq_io.mc_inst_ready[0];

  // Static prediction of the returned word: JAL target, otherwise fall through.
  assign jal_imm = {{11{fq_io.mc_inst_data[31]}}, fq_io.mc_inst_data[31],
                    fq_io.mc_inst_data[19:12], fq_io.mc_inst_data[20],
                    fq_io.mc_inst_data[30:21], 1'b0};
  assign pred = (fq_io.mc_inst_data[6:0] == 7'b1101111) ? req_pc_q + jal_imm
                                                        : req_pc_q + 32'd4;

  // Next-state: flush first, then request FSM, then queue push/pop and head view.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inst_d     = inst_q;
    pc_d       = pc_q;
    pred_d     = pred_q;
    need_d     = 1'b0;
    addr_d     = addr_q;
    push       = 1'b0;
    pop        = 1'b0;

    if (fq_io.flush) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = fq_io.redirect_pc;
      state_d    = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (count_q != Full) begin
            need_d   = 1'b1;
            addr_d   = fetch_pc_q;
            req_pc_d = fetch_pc_q;
            state_d  = StWait;
          end
        end
        StWait: begin
          // Stale or misrouted words carry the wrong tag and are dropped.
          if (fq_io.mc_inst_ready[1] && (fq_io.mc_inst_addr == req_pc_q)) begin
            push       = 1'b1;
            fetch_pc_d = pred;
            state_d    = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase

      pop = fq_io.iq_pop && (count_q != '0);

      if (push) begin
        inst_d[tail_q] = fq_io.mc_inst_data;
        pc_d[tail_q]   = req_pc_q;
        pred_d[tail_q] = pred;
        tail_d         = tail_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    // Head view uses the post-update arrays so a push into an empty queue shows at once.
    iq_valid_d = (count_d != '0);
    iq_inst_d  = inst_d[head_d];
    iq_pc_d    = pc_d[head_d];
    iq_pred_d  = pred_d[head_d];
  end

  // State registers; rdy=0 freezes everything including the request pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
        pred_q[i] <= '0;
      end
      need_q     <= 1'b0;
      addr_q     <= '0;
      iq_valid_q <= 1'b0;
      iq_inst_q  <= '0;
      iq_pc_q    <= '0;
      iq_pred_q  <= '0;
    end else if (fq_io.rdy) begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      pred_q     <= pred_d;
      need_q     <= need_d;
      addr_q     <= addr_d;
      iq_valid_q <= iq_valid_d;
      iq_inst_q  <= iq_inst_d;
      iq_pc_q    <= iq_pc_d;
      iq_pred_q  <= iq_pred_d;
    end
  end

  assign fq_io.need_instruction = need_q;
  assign fq_io.instruction_addr = addr_q;
  assign fq_io.iq_valid         = iq_valid_q;
  assign fq_io.iq_inst          = iq_inst_q;
  assign fq_io.iq_pc            = iq_pc_q;
  assign fq_io.iq_pred_pc       = iq_pred_q;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: bench plays memory controller and decoder.
module tb_instruction_fetch_queue;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  instruction_fetch_queue_if bus ();

  instruction_fetch_queue #(
    .DEPTH   (8),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .fq_io(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a request pulse and check its address.
  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    int n = 0;
    while (bus.need_instruction !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, {31'b0, bus.need_instruction}, 32'd1);
    chk({tag, "_addr"}, bus.instruction_addr, exp_addr);
  endtask

  task automatic respond(input logic [31:0] data, input logic [31:0] addr);
    bus.mc_inst_data  = data;
    bus.mc_inst_addr  = addr;
    bus.mc_inst_ready = 2'b10;
    tick();
    bus.mc_inst_ready = 2'b01;
  endtask

  task automatic do_flush(input logic [31:0] pc);
    bus.flush       = 1'b1;
    bus.redirect_pc = pc;
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic do_pop();
    bus.iq_pop = 1'b1;
    tick();
    bus.iq_pop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [31:0] seen_addr;
    bus.rdy           = 1'b1;
    bus.flush         = 1'b0;
    bus.redirect_pc   = '0;
    bus.mc_inst_data  = '0;
    bus.mc_inst_addr  = '0;
    bus.mc_inst_ready = 2'b01;
    bus.iq_pop        = 1'b0;

    // 1: reset state, first request, first word
    tick();
    tick();
    chk("rst_need", {31'b0, bus.need_instruction}, 32'd0);
    chk("rst_addr", bus.instruction_addr, 32'h0);
    chk("rst_valid", {31'b0, bus.iq_valid}, 32'd0);
    chk("rst_inst", bus.iq_inst, 32'h0);
    chk("rst_pc", bus.iq_pc, 32'h0);
    chk("rst_pred", bus.iq_pred_pc, 32'h0);
    rst = 1'b1;
    wait_req("t1_first", 32'h0);
    tick();
    chk("t1_pulse_one_cycle", {31'b0, bus.need_instruction}, 32'd0);
    respond(32'h0000_0013, 32'h0);
    chk("t1_valid", {31'b0, bus.iq_valid}, 32'd1);
    chk("t1_inst", bus.iq_inst, 32'h0000_0013);
    chk("t1_pc", bus.iq_pc, 32'h0);
    chk("t1_pred", bus.iq_pred_pc, 32'h4);
    wait_req("t1_next", 32'h4);

    // 2: JAL forward and backward
    do_flush(32'h10);
    chk("t2_flush_valid", {31'b0, bus.iq_valid}, 32'd0);
    wait_req("t2_a", 32'h10);
    respond(32'h0080_006F, 32'h10);
    chk("t2_fwd_pc", bus.iq_pc, 32'h10);
    chk("t2_fwd_pred", bus.iq_pred_pc, 32'h18);
    wait_req("t2_fwd_next", 32'h18);
    do_flush(32'h20);
    wait_req("t2_b", 32'h20);
    respond(32'hFF9F_F06F, 32'h20);
    chk("t2_bwd_pred", bus.iq_pred_pc, 32'h18);
    wait_req("t2_bwd_next", 32'h18);

    // 3: fill queue, verify stall, one pop releases exactly one request
    do_flush(32'h0);
    for (int i = 0; i < 8; i++) begin
      wait_req("t3_fill", 32'(i * 4));
      respond(32'h0000_0013, 32'(i * 4));
    end
    chk("t3_head_pc", bus.iq_pc, 32'h0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.need_instruction === 1'b1) pulses++;
    end
    chk("t3_full_no_req", 32'(pulses), 32'd0);
    chk("t3_full_valid", {31'b0, bus.iq_valid}, 32'd1);
    do_pop();
    chk("t3_pop_head_pc", bus.iq_pc, 32'h4);
    pulses    = 0;
    seen_addr = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.need_instruction === 1'b1) begin
        pulses++;
        seen_addr = bus.instruction_addr;
      end
    end
    chk("t3_one_req", 32'(pulses), 32'd1);
    chk("t3_req_addr", seen_addr, 32'h20);

    // 4: flush wins over a same-cycle response
    bus.mc_inst_data  = 32'h0000_0013;
    bus.mc_inst_addr  = 32'h20;
    bus.mc_inst_ready = 2'b10;
    do_flush(32'h100);
    bus.mc_inst_ready = 2'b01;
    chk("t4_valid", {31'b0, bus.iq_valid}, 32'd0);
    wait_req("t4_redirect", 32'h100);
    chk("t4_still_empty", {31'b0, bus.iq_valid}, 32'd0);

    // 5: mismatching tag ignored
    do_flush(32'h40);
    wait_req("t5", 32'h40);
    respond(32'h0000_0013, 32'h44);
    chk("t5_drop_valid", {31'b0, bus.iq_valid}, 32'd0);
    respond(32'h0000_0093, 32'h40);
    chk("t5_valid", {31'b0, bus.iq_valid}, 32'd1);
    chk("t5_inst", bus.iq_inst, 32'h0000_0093);
    chk("t5_pc", bus.iq_pc, 32'h40);
    chk("t5_pred", bus.iq_pred_pc, 32'h44);

    // 6a: push+pop at count=3 keeps count and order
    wait_req("t6_b", 32'h44);
    respond(32'h0000_0113, 32'h44);
    wait_req("t6_c", 32'h48);
    respond(32'h0000_0193, 32'h48);
    wait_req("t6_d", 32'h4C);
    bus.iq_pop = 1'b1;
    respond(32'h0000_0213, 32'h4C);
    bus.iq_pop = 1'b0;
    chk("t6_head1_pc", bus.iq_pc, 32'h44);
    chk("t6_head1_inst", bus.iq_inst, 32'h0000_0113);
    do_pop();
    chk("t6_head2_pc", bus.iq_pc, 32'h48);
    chk("t6_head2_inst", bus.iq_inst, 32'h0000_0193);
    do_pop();
    chk("t6_head3_pc", bus.iq_pc, 32'h4C);
    chk("t6_head3_inst", bus.iq_inst, 32'h0000_0213);
    chk("t6_head3_pred", bus.iq_pred_pc, 32'h50);
    do_pop();
    chk("t6_empty", {31'b0, bus.iq_valid}, 32'd0);

    // 6b: rdy=0 freeze mid-request, including an ignored response
    do_flush(32'h200);
    wait_req("t6_frz", 32'h200);
    bus.rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i >= 2) begin
        bus.mc_inst_data  = 32'h0000_0013;
        bus.mc_inst_addr  = 32'h200;
        bus.mc_inst_ready = 2'b10;
      end
      tick();
      chk("t6_frz_need", {31'b0, bus.need_instruction}, 32'd1);
      chk("t6_frz_addr", bus.instruction_addr, 32'h200);
      chk("t6_frz_valid", {31'b0, bus.iq_valid}, 32'd0);
    end
    bus.mc_inst_ready = 2'b01;
    bus.rdy = 1'b1;
    tick();
    chk("t6_resume_need", {31'b0, bus.need_instruction}, 32'd0);
    chk("t6_resume_valid", {31'b0, bus.iq_valid}, 32'd0);
    respond(32'h0000_0013, 32'h200);
    chk("t6_resume_pc", bus.iq_pc, 32'h200);
    chk("t6_resume_pred", bus.iq_pred_pc, 32'h204);
    wait_req("t6_resume_next", 32'h204);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
